// File: rtl/serial_axi_rx.sv
// serial_axi_rx: oversampling serial-to-parallel receiver.
// sclk/sdata/svalid are sampled as data in the aclk domain. MSB-first words of
// packet_length bits are assembled and presented on a valid/ready output
// toward a downstream FIFO.
module serial_axi_rx #(
  parameter int packet_length = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     sclk,
  input  logic                     sdata,
  input  logic                     svalid,
  output logic [packet_length-1:0] fifo_data,
  output logic                     fifo_valid,
  input  logic                     fifo_ready
);

  localparam int CNT_W = (packet_length > 2) ? $clog2(packet_length) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(packet_length - 1);

  // Synchronizer stages. All three inputs share the same depth so they stay aligned.
  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic sdata_meta_r, sdata_sync_r;
  logic svalid_meta_r, svalid_sync_r;

  logic [CNT_W-1:0]         cnt_r;
  logic [packet_length-2:0] shreg_r;

  logic                     rise_s;
  logic                     complete_s;
  logic                     transfer_s;
  logic [packet_length-1:0] word_s;

  // Two-flop synchronizers plus the previous-sclk flop used for edge detection.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sclk_meta_r   <= 1'b0;
      sclk_sync_r   <= 1'b0;
      sclk_prev_r   <= 1'b0;
      sdata_meta_r  <= 1'b0;
      sdata_sync_r  <= 1'b0;
      svalid_meta_r <= 1'b0;
      svalid_sync_r <= 1'b0;
    end else begin
      sclk_meta_r   <= sclk;
      sclk_sync_r   <= sclk_meta_r;
      sclk_prev_r   <= sclk_sync_r;
      sdata_meta_r  <= sdata;
      sdata_sync_r  <= sdata_meta_r;
      svalid_meta_r <= svalid;
      svalid_sync_r <= svalid_meta_r;
    end
  end

  // Edge detect, word-complete and handshake decode.
  always_comb begin
    rise_s     = sclk_sync_r & ~sclk_prev_r;
    word_s     = {shreg_r, sdata_sync_r};
    complete_s = rise_s & svalid_sync_r & (cnt_r == LAST_BIT);
    transfer_s = fifo_valid & fifo_ready;
  end

  // Bit counter and shift register. Dropping svalid discards a partial word.
  // The final bit bypasses the shift register and goes straight to the output.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_r   <= {CNT_W{1'b0}};
      shreg_r <= {(packet_length-1){1'b0}};
    end else if (!svalid_sync_r) begin
      cnt_r   <= {CNT_W{1'b0}};
    end else if (rise_s) begin
      if (cnt_r == LAST_BIT) begin
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        shreg_r <= word_s[packet_length-2:0];
        cnt_r   <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Output register. A word completing while the register is full and not
  // draining is dropped; the held word stays stable until accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      fifo_data  <= {packet_length{1'b0}};
      fifo_valid <= 1'b0;
    end else if (complete_s && (!fifo_valid || transfer_s)) begin
      fifo_data  <= word_s;
      fifo_valid <= 1'b1;
    end else if (transfer_s) begin
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= fifo_valid;
    end
  end

endmodule

// File: tb/tb_serial_axi_rx.sv
// Scoreboard bench for serial_axi_rx: expected words are queued as they are
// sent and popped by a monitor on every output handshake.
module tb_serial_axi_rx;

  localparam int PL = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          sclk = 1'b0;
  logic          sdata = 1'b0;
  logic          svalid = 1'b0;
  logic          fifo_ready = 1'b1;
  logic [PL-1:0] fifo_data;
  logic          fifo_valid;

  int            vectors = 0;
  int            miscompares = 0;
  int            xfers = 0;
  logic [PL-1:0] exp_q[$];

  logic          prev_hold = 1'b0;
  logic [PL-1:0] prev_data = '0;
  logic [PL-1:0] exp_word;

  serial_axi_rx #(.packet_length(PL)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .sclk      (sclk),
    .sdata     (sdata),
    .svalid    (svalid),
    .fifo_data (fifo_data),
    .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready)
  );

  always #5 aclk = ~aclk;

  // Inputs change 2 ns after the rising edge; checks in tasks happen there too.
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // One serial bit: 4 aclk cycles low with data set up, then 4 cycles high.
  task automatic send_bit(input logic b);
    sclk   = 1'b0;
    sdata  = b;
    svalid = 1'b1;
    repeat (4) tick();
    sclk = 1'b1;
    repeat (4) tick();
  endtask

  // Send the n most significant bits of w, MSB first.
  task automatic send_bits(input logic [PL-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[PL-1-i]);
  endtask

  task automatic idle(input int n);
    sclk   = 1'b0;
    svalid = 1'b0;
    repeat (n) tick();
  endtask

  // Wait (bounded) for the scoreboard to drain, then check the transfer count.
  task automatic check_drain(input string name, input int start, input int n);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    repeat (10) tick();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (xfers - start !== n) begin
      miscompares++;
      $display("FAIL %s_count: got %0d transfers, required %0d", name, xfers - start, n);
    end
  endtask

  // Monitor: output handshakes against the scoreboard, and hold stability.
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          vectors++;
          if (fifo_valid !== 1'b1 || fifo_data !== prev_data) begin
            miscompares++;
            $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h",
                     fifo_valid, fifo_data, prev_data);
          end
        end
        if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
          vectors++;
          xfers++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %h, required no word", fifo_data);
          end else begin
            exp_word = exp_q.pop_front();
            if (fifo_data !== exp_word) begin
              miscompares++;
              $display("FAIL word_data: got %h, required %h", fifo_data, exp_word);
            end
          end
        end
        prev_hold = (fifo_valid === 1'b1) && (fifo_ready !== 1'b1);
        prev_data = fifo_data;
      end
    end
  end

  task automatic test_reset();
    areset = 1'b1;
    svalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sclk = ~sclk;
      tick();
      vectors++;
      if (fifo_valid !== 1'b0 || fifo_data !== 32'h0000_0000) begin
        miscompares++;
        $display("FAIL reset_hold: got valid=%b data=%h, required valid=0 data=0", fifo_valid, fifo_data);
      end
    end
    areset = 1'b0;
    sclk   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (fifo_valid !== 1'b0 || fifo_data !== 32'h0000_0000) begin
        miscompares++;
        $display("FAIL reset_release: got valid=%b data=%h, required valid=0 data=0", fifo_valid, fifo_data);
      end
    end
    idle(8);
  endtask

  task automatic test_single();
    logic [PL-1:0] w;
    int start;
    w     = 32'hA5C3_0F01;
    start = xfers;
    exp_q.push_back(w);
    send_bits(w, PL-1);
    sclk  = 1'b0;
    sdata = w[0];
    repeat (4) tick();
    sclk = 1'b1;
    tick();              // edge E samples sclk high
    tick();              // E+1
    vectors++;
    if (fifo_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: got valid=%b at E+1, required 0", fifo_valid);
    end
    tick();              // E+2
    vectors++;
    if (fifo_valid !== 1'b1 || fifo_data !== w) begin
      miscompares++;
      $display("FAIL single_latency: got valid=%b data=%h at E+2, required valid=1 data=%h",
               fifo_valid, fifo_data, w);
    end
    tick();              // E+3
    vectors++;
    if (fifo_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_deassert: got valid=%b at E+3, required 0", fifo_valid);
    end
    idle(8);
    check_drain("single", start, 1);
  endtask

  task automatic test_back_to_back();
    int start;
    start = xfers;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h1234_5678);
    send_bits(32'hDEAD_BEEF, PL);
    send_bits(32'h1234_5678, PL);
    idle(8);
    check_drain("back_to_back", start, 2);
  endtask

  task automatic test_backpressure();
    int start;
    start      = xfers;
    fifo_ready = 1'b0;
    exp_q.push_back(32'h0000_0001);
    send_bits(32'h0000_0001, PL);
    send_bits(32'h0000_0002, PL);
    idle(8);
    vectors++;
    if (fifo_valid !== 1'b1 || fifo_data !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL backpressure_held: got valid=%b data=%h, required valid=1 data=00000001",
               fifo_valid, fifo_data);
    end
    fifo_ready = 1'b1;
    check_drain("backpressure", start, 1);
  endtask

  task automatic test_svalid_drop();
    int start;
    start = xfers;
    send_bits(32'hB6D0_0000, 10);
    idle(8);
    exp_q.push_back(32'h0000_FFFF);
    send_bits(32'h0000_FFFF, PL);
    idle(8);
    check_drain("svalid_drop", start, 1);
  endtask

  task automatic test_reset_mid_word();
    int start;
    start = xfers;
    send_bits(32'h9F3A_5000, 20);
    sclk   = 1'b0;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    repeat (4) tick();
    vectors++;
    if (fifo_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_valid: got valid=%b, required 0", fifo_valid);
    end
    exp_q.push_back(32'hCAFE_F00D);
    send_bits(32'hCAFE_F00D, PL);
    idle(8);
    check_drain("reset_mid", start, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_svalid_drop();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
